// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: reset PC, the NOP encoding and the
// {pc, instr} record that travels from instruction memory to decode.
package cpu_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0040_0020;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries.
// Flush is synchronous and wins over push and pop in the same cycle.
// Push when full and pop when empty are ignored.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign do_push = push_i & (count_q != FULL);
    assign do_pop  = pop_i & (count_q != '0);

    // Pointer and occupancy next-state; flush clears everything.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch front end: issues in-order single-outstanding reads,
// buffers returned {pc, instr} pairs and presents the head to decode.
// Handshake: imem_req is accepted in the cycle it is high; imem_valid
// returns the oldest outstanding read; decode consumes the head whenever
// valid_if=1 and id_stall=0. A redirect flushes the buffer and marks any
// in-flight response for discard.
module if_fetch_buffer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        initPC,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        valid_if,
    output logic [31:0] instr_if,
    output logic [31:0] pc_if
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  pc_q, pc_d;
    logic         busy_q, busy_d;
    logic         squash_q, squash_d;

    logic         push, pop, flush;
    fetch_entry_t push_data, head;
    logic [CW-1:0] fifo_count;
    logic [CW:0]  occupancy;
    logic         room;

    // Buffered entries plus the outstanding request must stay below DEPTH
    // so that every response is guaranteed a slot.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, busy_q};
    assign room      = occupancy < (CW + 1)'(DEPTH);

    assign imem_req  = ~initPC & ~redirect & (~busy_q | imem_valid) & room;
    assign imem_addr = fetch_pc_q;

    assign push      = imem_valid & ~squash_q & ~redirect & ~initPC;
    assign push_data = '{pc: pc_q, instr: imem_rdata};
    assign pop       = valid_if & ~id_stall & ~redirect;
    assign flush     = initPC | redirect;

    // Fetch PC, outstanding-request and squash next-state.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        busy_d     = busy_q;
        squash_d   = squash_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            if (imem_valid) begin
                busy_d   = 1'b0;
                squash_d = 1'b0;
            end else if (busy_q) begin
                squash_d = 1'b1;
            end
        end else begin
            if (imem_valid) begin
                busy_d   = 1'b0;
                squash_d = 1'b0;
            end
            if (imem_req) begin
                pc_d       = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
                busy_d     = 1'b1;
            end
        end
    end

    // Fetch state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (initPC) begin
            fetch_pc_q <= RESET_PC;
            pc_q       <= '0;
            busy_q     <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            busy_q     <= busy_d;
            squash_q   <= squash_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    assign valid_if = (fifo_count != '0);
    assign instr_if = valid_if ? head.instr : NOP_INSTR;
    assign pc_if    = valid_if ? head.pc : 32'h0;

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer: per-cycle vector table for streaming
// and stall fill, then hand sequences for redirect, reset and PC wrap.
module tb_if_fetch_buffer;

    logic        clk = 1'b0;
    logic        initPC, redirect, id_stall, imem_valid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, valid_if;
    logic [31:0] imem_addr, instr_if, pc_if;

    // Clock.
    always #5 clk = ~clk;

    if_fetch_buffer dut (
        .clk         (clk),
        .initPC      (initPC),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_stall    (id_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .valid_if    (valid_if),
        .instr_if    (instr_if),
        .pc_if       (pc_if)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory model state: one outstanding read, fixed latency.
    int          cyc = 0;
    int          lat = 1;
    bit          mem_busy = 1'b0;
    int          mem_resp_cyc = 0;
    logic [31:0] mem_addr = '0;

    // Values sampled #1 after the negedge, before the cycle's rising edge.
    logic        s_valid, s_req;
    logic [31:0] s_pc, s_instr, s_addr, s_cnt;

    logic [31:0] exp_q [$];

    typedef struct {
        bit          rst_before;
        bit          stall;
        bit          exp_valid;
        logic [31:0] exp_pc;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          chk_cnt;
    } vec_t;

    vec_t vecs [22];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    function automatic vec_t mk(input bit r, input bit s, input bit v, input logic [31:0] p,
                                input bit q, input logic [31:0] a, input bit c);
        vec_t t;
        t.rst_before = r; t.stall = s; t.exp_valid = v; t.exp_pc = p;
        t.exp_req = q; t.exp_addr = a; t.chk_cnt = c;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive memory response, sample, update model, advance.
    task automatic cycle();
        imem_valid = mem_busy && (cyc == mem_resp_cyc);
        imem_rdata = imem_valid ? mem_word(mem_addr) : 32'h0;
        #1;
        s_valid = valid_if;
        s_pc    = pc_if;
        s_instr = instr_if;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_cnt   = 32'(dut.fifo_count);
        if (imem_valid) mem_busy = 1'b0;
        if (initPC) begin
            mem_busy = 1'b0;
        end else if (imem_req) begin
            mem_busy     = 1'b1;
            mem_addr     = imem_addr;
            mem_resp_cyc = cyc + lat;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        initPC   = 1'b1;
        redirect = 1'b0;
        id_stall = 1'b0;
        cycle();
        cycle();
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_instr", s_instr, 32'h0);
        check("rst_pc", s_pc, 32'h0);
        check("rst_req", 32'(s_req), 32'd0);
        check("rst_addr", s_addr, 32'h0040_0020);
        initPC = 1'b0;
    endtask

    initial begin
        initPC      = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_stall    = 1'b0;
        imem_valid  = 1'b0;
        imem_rdata  = 32'h0;
        @(negedge clk);

        // Streaming with 1-cycle memory.
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_0020, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_0024, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0028, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b1, 32'h0040_0024, 1'b1, 32'h0040_002C, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b1, 32'h0040_0028, 1'b1, 32'h0040_0030, 1'b0);
        // Stall fill: 10 stalled cycles, then drain in PC order.
        vecs[5]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0040_0020, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0040_0024, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0028, 1'b0);
        vecs[8]  = mk(1'b0, 1'b1, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_002C, 1'b0);
        vecs[9]  = mk(1'b0, 1'b1, 1'b1, 32'h0040_0020, 1'b0, 32'h0,        1'b0);
        for (int i = 10; i < 15; i++)
            vecs[i] = mk(1'b0, 1'b1, 1'b1, 32'h0040_0020, 1'b0, 32'h0, 1'b1);
        vecs[15] = mk(1'b0, 1'b0, 1'b1, 32'h0040_0020, 1'b0, 32'h0,        1'b0);
        vecs[16] = mk(1'b0, 1'b0, 1'b1, 32'h0040_0024, 1'b1, 32'h0040_0030, 1'b0);
        vecs[17] = mk(1'b0, 1'b0, 1'b1, 32'h0040_0028, 1'b1, 32'h0040_0034, 1'b0);
        vecs[18] = mk(1'b0, 1'b0, 1'b1, 32'h0040_002C, 1'b1, 32'h0040_0038, 1'b0);
        vecs[19] = mk(1'b0, 1'b0, 1'b1, 32'h0040_0030, 1'b1, 32'h0040_003C, 1'b0);
        vecs[20] = mk(1'b0, 1'b0, 1'b1, 32'h0040_0034, 1'b1, 32'h0040_0040, 1'b0);
        vecs[21] = mk(1'b0, 1'b0, 1'b1, 32'h0040_0038, 1'b1, 32'h0040_0044, 1'b0);

        lat = 1;
        for (int i = 0; i < 22; i++) begin
            if (vecs[i].rst_before) do_reset();
            id_stall = vecs[i].stall;
            redirect = 1'b0;
            cycle();
            check($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_pc", i), s_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_instr", i), s_instr,
                  vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : 32'h0);
            check($sformatf("vec%0d_req", i), 32'(s_req), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req)
                check($sformatf("vec%0d_addr", i), s_addr, vecs[i].exp_addr);
            if (vecs[i].chk_cnt)
                check($sformatf("vec%0d_count", i), s_cnt, 32'd4);
        end

        // Redirect while a 3-cycle read is in flight.
        do_reset();
        lat = 3;
        cycle();
        check("rdf_req0", 32'(s_req), 32'd1);
        check("rdf_addr0", s_addr, 32'h0040_0020);
        redirect = 1'b1; redirect_pc = 32'h0040_0100;
        cycle();
        redirect = 1'b0;
        check("rdf_req_busy", 32'(s_req), 32'd0);
        cycle();
        check("rdf_valid_after", 32'(s_valid), 32'd0);
        check("rdf_addr_new", s_addr, 32'h0040_0100);
        cycle();
        check("rdf_reissue_req", 32'(s_req), 32'd1);
        check("rdf_reissue_addr", s_addr, 32'h0040_0100);
        cycle();
        check("rdf_stale_dropped", 32'(s_valid), 32'd0);
        cycle();
        cycle();
        cycle();
        check("rdf_first_valid", 32'(s_valid), 32'd1);
        check("rdf_first_pc", s_pc, 32'h0040_0100);
        check("rdf_first_instr", s_instr, mem_word(32'h0040_0100));

        // Redirect in the same cycle as a response.
        do_reset();
        lat = 1;
        cycle();
        redirect = 1'b1; redirect_pc = 32'h0040_0200;
        cycle();
        redirect = 1'b0;
        check("rco_req_during", 32'(s_req), 32'd0);
        cycle();
        check("rco_valid_after", 32'(s_valid), 32'd0);
        check("rco_req_next", 32'(s_req), 32'd1);
        check("rco_addr_next", s_addr, 32'h0040_0200);
        cycle();
        cycle();
        check("rco_new_valid", 32'(s_valid), 32'd1);
        check("rco_new_pc", s_pc, 32'h0040_0200);

        // Reset with three buffered entries and a read outstanding.
        do_reset();
        lat = 1;
        id_stall = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        initPC = 1'b1;
        cycle();
        check("mid_count_before", s_cnt, 32'd3);
        initPC = 1'b0;
        id_stall = 1'b0;
        cycle();
        check("mid_valid_after", 32'(s_valid), 32'd0);
        check("mid_addr_after", s_addr, 32'h0040_0020);
        check("mid_req_after", 32'(s_req), 32'd1);
        exp_q = {32'h0040_0020, 32'h0040_0024, 32'h0040_0028, 32'h0040_002C};
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_valid && exp_q.size() > 0) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("mid_restart_pc", s_pc, e);
                check("mid_restart_instr", s_instr, mem_word(e));
            end
        end
        check("mid_restart_drained", 32'(exp_q.size()), 32'd0);

        // Fetch PC wraps past the top of the address space.
        do_reset();
        lat = 1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        cycle();
        check("wrap_req0", 32'(s_req), 32'd1);
        check("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        cycle();
        check("wrap_addr1", s_addr, 32'h0000_0000);
        cycle();
        check("wrap_pc0", s_pc, 32'hFFFF_FFFC);
        cycle();
        check("wrap_pc1", s_pc, 32'h0000_0000);
        check("wrap_instr1", s_instr, mem_word(32'h0000_0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
